// File: rtl/serial_mul_pkg.sv
// Shared constants and FSM state type for the serial 1024x256 multiplier.
package serial_mul_pkg;

   localparam int unsigned A_W     = 1024;
   localparam int unsigned B_W     = 256;
   localparam int unsigned CHUNK_W = 256;
   localparam int unsigned NCHUNK  = A_W / CHUNK_W;

   typedef enum logic [1:0] {
      CAPTURE = 2'd0,
      MUL     = 2'd1,
      UPDATE  = 2'd2
   } state_t;

endpackage

// File: rtl/mul_chunk_256.sv
// Combinational 256x256 -> 512 unsigned multiplier for one partial product.
module mul_chunk_256 (
   input  logic [255:0] a,
   input  logic [255:0] b,
   output logic [511:0] p
);

   always_comb p = a * b;

endmodule

// File: rtl/serial_mul_1024x256.sv
// Free-running serial multiplier: Out = In1 * In2, one 256-bit chunk per clock.
// Optional macro SERIAL_MUL_VALID_EN adds the one-cycle out_valid strobe.
module serial_mul_1024x256
   import serial_mul_pkg::*;
(
   input  logic               clk,
   input  logic               rstn,
   input  logic [A_W-1:0]     In1,
   input  logic [B_W-1:0]     In2,
   output logic [A_W+B_W-1:0] Out
`ifdef SERIAL_MUL_VALID_EN
   ,
   output logic               out_valid
`endif
);

   localparam int unsigned P_W   = A_W + B_W;
   localparam int unsigned IDX_W = $clog2(NCHUNK);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

   state_t               state, state_nxt;
   logic [A_W-1:0]       a_reg;
   logic [B_W-1:0]       b_reg;
   logic [P_W-1:0]       acc;
   logic [IDX_W-1:0]     idx;
   logic [CHUNK_W-1:0]   a_chunk;
   logic [CHUNK_W+B_W-1:0] pp;
   logic [P_W-1:0]       pp_shifted;

   always_comb a_chunk = a_reg[idx*CHUNK_W +: CHUNK_W];

   mul_chunk_256 u_mul (
      .a (a_chunk),
      .b (b_reg),
      .p (pp)
   );

   // Partial product weighted by its chunk position before accumulation
   always_comb pp_shifted = P_W'(pp) << (CHUNK_W * idx);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= CAPTURE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         CAPTURE: state_nxt = MUL;
         MUL:     if (idx == LAST_IDX) state_nxt = UPDATE;
         UPDATE:  state_nxt = CAPTURE;
         default: state_nxt = CAPTURE;
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         a_reg <= '0;
         b_reg <= '0;
         acc   <= '0;
         idx   <= '0;
         Out   <= '0;
      end else begin
         case (state)
            CAPTURE: begin
               a_reg <= In1;
               b_reg <= In2;
               acc   <= '0;
               idx   <= '0;
            end
            MUL: begin
               acc <= acc + pp_shifted;
               idx <= idx + 1'b1;
            end
            UPDATE:  Out <= acc;
            default: ;
         endcase
      end
   end

`ifdef SERIAL_MUL_VALID_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) out_valid <= 1'b0;
      else       out_valid <= (state == UPDATE);
   end
`endif

endmodule

// File: tb/tb_serial_mul_1024x256.sv
// Directed self-checking bench for serial_mul_1024x256.
module tb_serial_mul_1024x256;

   logic           clk;
   logic           rstn;
   logic [1023:0]  In1;
   logic [255:0]   In2;
   logic [1279:0]  Out;
`ifdef SERIAL_MUL_VALID_EN
   logic           out_valid;
`endif

   int unsigned total = 0;
   int unsigned bad   = 0;

   serial_mul_1024x256 dut (
      .clk  (clk),
      .rstn (rstn),
      .In1  (In1),
      .In2  (In2),
      .Out  (Out)
`ifdef SERIAL_MUL_VALID_EN
      ,
      .out_valid (out_valid)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [1279:0] got, input logic [1279:0] exp);
      int diff_bit;
      total++;
      if (got !== exp) begin
         bad++;
         diff_bit = -1;
         for (int i = 0; i < 1280; i++)
            if (diff_bit < 0 && got[i] !== exp[i]) diff_bit = i;
         $display("FAIL %s got_hi=%h got_lo=%h exp_hi=%h exp_lo=%h first_diff_bit=%0d",
                  tag, got[1279:1216], got[63:0], exp[1279:1216], exp[63:0], diff_bit);
      end
   endtask

   // Called at a negedge with rstn just released: exact 6-edge latency.
   task automatic release_expect(input string tag, input logic [1279:0] exp);
      rstn = 1'b1;
      for (int e = 1; e <= 6; e++) begin
         @(negedge clk);
         if (e < 6) check_val({tag, "_pre"}, Out, '0);
         else       check_val(tag, Out, exp);
`ifdef SERIAL_MUL_VALID_EN
         check_val({tag, "_vld"}, 1280'(out_valid), (e == 6) ? 1280'(1) : 1280'(0));
`endif
      end
   endtask

   // Bounded wait for a new product; Out must hold the old one until then.
   task automatic wait_prod(input string tag, input logic [1279:0] exp, input logic [1279:0] old);
      bit found;
      found = 1'b0;
      for (int e = 0; e < 11 && !found; e++) begin
         @(negedge clk);
         if (Out === exp) found = 1'b1;
         else             check_val({tag, "_hold"}, Out, old);
      end
      check_val(tag, Out, exp);
      for (int s = 0; s < 12; s++) begin
         @(negedge clk);
         check_val({tag, "_stable"}, Out, exp);
      end
   endtask

   initial begin
      logic [255:0]  ones256;
      logic [1279:0] exp, prev;

      ones256 = '1;
      rstn = 1'b0;
      In1  = 1024'd33;
      In2  = 256'd44;

      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         check_val("reset_out", Out, '0);
      end
      release_expect("small", 1280'd1452);
      for (int s = 0; s < 12; s++) begin
         @(negedge clk);
         check_val("small_stable", Out, 1280'd1452);
      end

      while ($time < 3000) @(negedge clk);
      In1 = 1024'd555;
      In2 = 256'd45;
      wait_prod("change", 1280'd24975, 1280'd1452);

      prev = 1280'd24975;
      for (int k = 0; k < 4; k++) begin
         In1 = 1024'(1) << (256 * k);
         In2 = ones256;
         exp = 1280'(ones256) << (256 * k);
         wait_prod($sformatf("chunk%0d", k), exp, prev);
         prev = exp;
      end

      // (2^1024-1)(2^256-1) = 2^1280 - 2^1024 - 2^256 + 1
      In1 = '1;
      In2 = ones256;
      exp = 1280'(ones256) << 1024;
      exp = exp - (1280'(1) << 256) + 1280'(1);
      wait_prod("max", exp, prev);

      // Realign to a known phase, then reset while in MUL
      @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      release_expect("max_realign", exp);
      @(negedge clk);
      @(negedge clk);
      In1 = 1024'd1000;
      In2 = 256'd7;
      rstn = 1'b0;
      #1;
      check_val("midreset_out", Out, '0);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check_val("midreset_hold", Out, '0);
      end
      release_expect("after_reset", 1280'd7000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/serial_mul_1024x256.md
Name: serial_mul_1024x256

Overview:
- Free-running multi-cycle multiplier: Out = In1 (1024 b) × In2 (256 b), full-precision 1280 b product.
- Splits In1 into four 256-bit chunks; one 256×256 partial product is accumulated per clock.
- No start/done handshake: the block continuously samples its inputs and refreshes Out with the latest complete product.
- Used as the 256-bit-unit core of the 1024-bit large-multiplication datapath.

Parameters:
- A_W, 1024, width of In1 (multiplicand); must be a multiple of CHUNK_W.
- B_W, 256, width of In2 (multiplier).
- CHUNK_W, 256, partial-product chunk width; NCHUNK = A_W/CHUNK_W = 4.

Ports:
- clk  input  1  rising-edge clock, the only clock.
- rstn  input  1  asynchronous active-low reset.
- In1  input  A_W  multiplicand, unsigned.
- In2  input  B_W  multiplier, unsigned.
- Out  output  A_W+B_W (1280)  last completed product, unsigned, registered.

Behaviour:
- Reset (rstn=0, asynchronous):
  - Out=0, accumulator=0, chunk index=0, captured operands=0, state=CAPTURE.
  - Reset mid-operation aborts the product in flight; no partial value ever reaches Out.
- FSM states: CAPTURE -> MUL (NCHUNK cycles) -> UPDATE -> CAPTURE, looping forever.
- CAPTURE (1 edge): a_reg<=In1, b_reg<=In2, acc<=0, idx<=0.
- MUL (edges 1..4 after capture):
  - acc <= acc + ((a_reg[idx*256 +: 256] × b_reg) << (256*idx)); idx++.
  - Leave to UPDATE after idx=NCHUNK-1.
- UPDATE (edge 5): Out<=acc; next state CAPTURE.
- Period: 6 clock edges per result.
- Latency: Out reflects operands sampled at a CAPTURE edge exactly 5 edges later.
- Input changes between CAPTURE edges are ignored until the next CAPTURE. Out shows new stable inputs within ≤11 rising edges of the change.
- Out holds its value between UPDATE edges.
- Arithmetic: unsigned, no truncation. Each partial product is 512 b; acc is 1280 b and never overflows.
- Inputs need not be stable relative to anything except setup/hold at CAPTURE.

Optional Feature:
- Macro SERIAL_MUL_VALID_EN.
- Defined: adds output port out_valid (1 b, after Out in the port list).
  - out_valid=1 for exactly one cycle, registered with the UPDATE edge (same edge Out changes).
  - out_valid resets to 0.
- Undefined: port absent; all other behaviour identical.

Decomposition:
- Shared package serial_mul_pkg: A_W, B_W, CHUNK_W, NCHUNK constants; state enum typedef (CAPTURE, MUL, UPDATE).
- One sub-module: mul_chunk_256, combinational 256×256 -> 512 unsigned multiplier, instantiated once and fed by the idx-selected chunk.

Test Plan:
- Reset: hold rstn=0 for 3 cycles -> Out=0 throughout; first CAPTURE on the first edge after release.
- Small operands: In1=33, In2=44 -> Out=1452 within ≤11 edges, stable thereafter.
- Operand change: at 3000 ns set In1=555, In2=45 -> Out=24975 within ≤11 edges; Out holds 1452 until that UPDATE edge.
- Chunk coverage: In1=1<<(256k) for k=0..3, In2=2^256-1 -> Out=(2^256-1)<<(256k).
- Max operands: In1=2^1024-1, In2=2^256-1 -> Out=(2^1024-1)(2^256-1), no overflow.
- Mid-operation reset: assert rstn=0 during MUL -> Out=0 immediately; after release, correct product for current inputs appears 6 edges later.
